// File: rtl/fsm_timed_seq.sv
// fsm_timed_seq: Moore trigger sequencer with rise/fall hold-off down-counter.
// Define FSM_FALL_PULSE_EN to add the QF fall-accepted pulse output.
module fsm_timed_seq #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             X,
  input  logic [CNT_W-1:0] DLY_RISE,
  input  logic [CNT_W-1:0] DLY_FALL,
  output logic             Q,
  output logic             START,
  output logic             BUSY,
`ifdef FSM_FALL_PULSE_EN
  output logic             QF,
`endif
  output logic [2:0]       STATE
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    WAIT_LO = 3'd3,
    FALL    = 3'd4,
    HOLD_LO = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic q_q, q_d, start_q, start_d, busy_q, busy_d;
  logic xs, cnt_zero, holding;
  if (SYNC_STAGES == 0) begin : g_direct
    assign xs = X;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = (sync_q << 1) | SYNC_STAGES'(X);
    always_ff @(posedge clk or negedge reset)
      if (!reset) sync_q <= '0;
      else sync_q <= sync_d;
    assign xs = sync_q[SYNC_STAGES-1];
  end
  assign cnt_zero = cnt_q == '0;
  assign holding  = state_q == HOLD_HI || state_q == HOLD_LO;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = xs ? RISE : IDLE;
      RISE:    state_d = HOLD_HI;
      HOLD_HI: state_d = cnt_zero ? WAIT_LO : HOLD_HI;
      WAIT_LO: state_d = xs ? WAIT_LO : FALL;
      FALL:    state_d = HOLD_LO;
      HOLD_LO: state_d = cnt_zero ? IDLE : HOLD_LO;
      default: state_d = IDLE;
    endcase
    // Counter saturates at zero; the hold exits on the cycle it reads zero.
    cnt_d   = state_q == RISE ? DLY_RISE :
              state_q == FALL ? DLY_FALL :
              (holding && !cnt_zero) ? cnt_q - CNT_W'(1) : cnt_q;
    q_d     = state_d == RISE;
    start_d = state_d == RISE || state_d == FALL;
    busy_d  = state_d == HOLD_HI || state_d == HOLD_LO;
  end
`ifdef FSM_FALL_PULSE_EN
  logic qf_q;
  assign QF = qf_q;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FSM_FALL_PULSE_EN
      qf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      start_q <= start_d;
      busy_q  <= busy_d;
`ifdef FSM_FALL_PULSE_EN
      qf_q    <= state_d == FALL;
`endif
    end
  assign Q     = q_q;
  assign START = start_q;
  assign BUSY  = busy_q;
  assign STATE = state_q;
endmodule

// File: tb/tb_fsm_timed_seq.sv
// tb_fsm_timed_seq: directed checks of fsm_timed_seq with an 8-bit/2-stage and a 4-bit/unsynchronised instance.
module tb_fsm_timed_seq;
  logic clk = 1'b0, reset = 1'b0, x = 1'b0, x4 = 1'b0;
  logic [7:0] dr = '0, df = '0;
  logic [3:0] dr4 = '0, df4 = '0;
  logic q, st, busy, q4, st4, busy4;
  logic [2:0] state, state4;
  int vectors = 0, errors = 0;
  int nq, ns, nb, nq4, ns4, nb4;
`ifdef FSM_FALL_PULSE_EN
  logic qf, qf4;
  int nqf, nqf4;
`endif
  always #5 clk = ~clk;
  fsm_timed_seq #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .X(x), .DLY_RISE(dr), .DLY_FALL(df),
    .Q(q), .START(st), .BUSY(busy),
`ifdef FSM_FALL_PULSE_EN
    .QF(qf),
`endif
    .STATE(state));
  fsm_timed_seq #(.CNT_W(4), .SYNC_STAGES(0)) dut4 (
    .clk(clk), .reset(reset), .X(x4), .DLY_RISE(dr4), .DLY_FALL(df4),
    .Q(q4), .START(st4), .BUSY(busy4),
`ifdef FSM_FALL_PULSE_EN
    .QF(qf4),
`endif
    .STATE(state4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    nq = 0; ns = 0; nb = 0; nq4 = 0; ns4 = 0; nb4 = 0;
`ifdef FSM_FALL_PULSE_EN
    nqf = 0; nqf4 = 0;
`endif
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      nq += int'(q); ns += int'(st); nb += int'(busy);
      nq4 += int'(q4); ns4 += int'(st4); nb4 += int'(busy4);
`ifdef FSM_FALL_PULSE_EN
      nqf += int'(qf); nqf4 += int'(qf4);
`endif
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget && state !== s; i++) step();
    vectors++;
    if (state !== s) begin errors++; $display("FAIL %s: state %0d, wanted %0d within %0d cycles", name, state, s, budget); end
  endtask

  task automatic test_reset();
    reset = 1'b0; x = 1'b1; dr = 8'd3; df = 8'd0;
    repeat (3) step();
    vectors += 5;
    if (q !== 1'b0) begin errors++; $display("FAIL reset_q: got %b want 0", q); end
    if (st !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", st); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    if (state4 !== 3'd0) begin errors++; $display("FAIL reset_state4: got %0d want 0", state4); end
    #2 reset = 1'b1;
    step();
    vectors++;
    if (state !== 3'd0) begin errors++; $display("FAIL sync_edge1_state: got %0d want 0", state); end
    step();
    vectors++;
    if (q !== 1'b0) begin errors++; $display("FAIL sync_edge2_q: got %b want 0", q); end
    step();
    vectors += 3;
    if (q !== 1'b1) begin errors++; $display("FAIL sync_edge3_q: got %b want 1", q); end
    if (st !== 1'b1) begin errors++; $display("FAIL sync_edge3_start: got %b want 1", st); end
    if (state !== 3'd1) begin errors++; $display("FAIL sync_edge3_state: got %0d want 1", state); end
  endtask

  task automatic test_hold_high();
    clear();
    run(12);
    vectors += 4;
    if (nq !== 0) begin errors++; $display("FAIL hold_hi_extra_q: got %0d want 0", nq); end
    if (ns !== 0) begin errors++; $display("FAIL hold_hi_extra_start: got %0d want 0", ns); end
    if (nb !== 4) begin errors++; $display("FAIL hold_hi_busy_cycles: got %0d want 4", nb); end
    if (state !== 3'd3) begin errors++; $display("FAIL hold_hi_end_state: got %0d want 3", state); end
  endtask

  task automatic test_back_to_back();
    dr = 8'd0; df = 8'd0;
    clear();
    for (int p = 0; p < 3; p++) begin
      x = 1'b0; run(6);
      x = 1'b1; run(6);
    end
    run(6);
    vectors += 4;
    if (nq !== 3) begin errors++; $display("FAIL b2b_q: got %0d want 3", nq); end
    if (ns !== 6) begin errors++; $display("FAIL b2b_start: got %0d want 6", ns); end
    if (nb !== 6) begin errors++; $display("FAIL b2b_busy: got %0d want 6", nb); end
    if (state !== 3'd3) begin errors++; $display("FAIL b2b_end_state: got %0d want 3", state); end
`ifdef FSM_FALL_PULSE_EN
    vectors++;
    if (nqf !== 3) begin errors++; $display("FAIL b2b_qf: got %0d want 3", nqf); end
`endif
  endtask

  task automatic test_glitch();
    df = 8'd8;
    x = 1'b0;
    wait_state(3'd5, 10, "glitch_reach_hold_lo");
    x = 1'b1; step(); x = 1'b0;
    clear();
    run(20);
    vectors += 5;
    if (nq !== 0) begin errors++; $display("FAIL glitch_q: got %0d want 0", nq); end
    if (ns !== 0) begin errors++; $display("FAIL glitch_start: got %0d want 0", ns); end
    if (nb !== 7) begin errors++; $display("FAIL glitch_busy_rest: got %0d want 7", nb); end
    if (state !== 3'd0) begin errors++; $display("FAIL glitch_end_state: got %0d want 0", state); end
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    dr = 8'd9; x = 1'b1;
    wait_state(3'd1, 10, "areset_first_rise");
    step();
    repeat (4) step();
    vectors++;
    if (state !== 3'd2) begin errors++; $display("FAIL areset_pre_state: got %0d want 2", state); end
    #2 reset = 1'b0;
    #1;
    vectors += 3;
    if (state !== 3'd0) begin errors++; $display("FAIL areset_state: got %0d want 0", state); end
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    if (q !== 1'b0) begin errors++; $display("FAIL areset_q: got %b want 0", q); end
    #1 reset = 1'b1;
    wait_state(3'd1, 10, "areset_restart_rise");
    vectors += 2;
    if (q !== 1'b1) begin errors++; $display("FAIL restart_q: got %b want 1", q); end
    if (st !== 1'b1) begin errors++; $display("FAIL restart_start: got %b want 1", st); end
    clear();
    run(14);
    vectors += 3;
    if (nb !== 10) begin errors++; $display("FAIL restart_busy: got %0d want 10", nb); end
    if (nq !== 0) begin errors++; $display("FAIL restart_extra_q: got %0d want 0", nq); end
    if (state !== 3'd3) begin errors++; $display("FAIL restart_end_state: got %0d want 3", state); end
  endtask

  task automatic test_cnt4_max();
    dr4 = 4'd0; df4 = 4'd15;
    x4 = 1'b1;
    step();
    vectors += 2;
    if (state4 !== 3'd1) begin errors++; $display("FAIL c4_rise_state: got %0d want 1", state4); end
    if (q4 !== 1'b1) begin errors++; $display("FAIL c4_rise_q: got %b want 1", q4); end
    step(); step();
    vectors++;
    if (state4 !== 3'd3) begin errors++; $display("FAIL c4_wait_lo_state: got %0d want 3", state4); end
    x4 = 1'b0;
    clear();
    run(25);
    vectors += 4;
    if (nb4 !== 16) begin errors++; $display("FAIL c4_busy_max: got %0d want 16", nb4); end
    if (ns4 !== 1) begin errors++; $display("FAIL c4_start: got %0d want 1", ns4); end
    if (nq4 !== 0) begin errors++; $display("FAIL c4_q: got %0d want 0", nq4); end
    if (state4 !== 3'd0) begin errors++; $display("FAIL c4_end_state: got %0d want 0", state4); end
`ifdef FSM_FALL_PULSE_EN
    vectors++;
    if (nqf4 !== 1) begin errors++; $display("FAIL c4_qf: got %0d want 1", nqf4); end
`endif
  endtask

  initial begin
    clear();
    test_reset();
    test_hold_high();
    test_back_to_back();
    test_glitch();
    test_async_reset();
    test_cnt4_max();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
